// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: FSM encoding,
// simulation debounce length and counter sizing helper.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2,
    ST_REPEAT  = 2'd3
  } btn_state_t;

  localparam int SIM_DB_CNT = 4;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, debouncer, press/hold/repeat FSM
// and registered strobe outputs.
module button_channel
  import btn_pkg::*;
#(
  parameter bit SIM      = 1'b0,
  parameter int DB_CNT   = 1_000_000,
  parameter int LONG_CNT = 50_000_000,
  parameter int RPT_CNT  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       repeat_en,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       toggle,
  output logic       level,
  output logic [1:0] state_dbg
);

  localparam int DB_EFF = SIM ? SIM_DB_CNT : DB_CNT;
  localparam int DB_W   = cnt_width(DB_EFF);
  localparam int HOLD_W = cnt_width(LONG_CNT);
  localparam int RPT_W  = cnt_width(RPT_CNT);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_EFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(RPT_CNT - 1);

  logic sync_a;
  logic synced;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      synced <= 1'b0;
    end else begin
      sync_a <= button;
      synced <= sync_a;
    end
  end

  // Accept a new level only after it has differed for DB_EFF consecutive samples.
  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (synced == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt >= DB_LAST) begin
      db_level <= synced;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              press_d, release_d, long_d, repeat_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    // A falling level overrides any count maturing in the same cycle.
    if (state_q != ST_IDLE && !db_level) begin
      state_d    = ST_IDLE;
      release_d  = 1'b1;
      hold_cnt_d = '0;
      rpt_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (db_level) begin
            state_d    = ST_PRESSED;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end
        end
        ST_PRESSED: begin
          if (hold_cnt_q >= HOLD_LAST) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            rpt_cnt_d  = '0;
            state_d    = repeat_en ? ST_REPEAT : ST_HELD;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (repeat_en) begin
            state_d   = ST_REPEAT;
            rpt_cnt_d = '0;
          end
        end
        ST_REPEAT: begin
          if (!repeat_en) begin
            state_d   = ST_HELD;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q >= RPT_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      rpt_cnt_q     <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      toggle        <= 1'b0;
      level         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      toggle        <= toggle ^ press_d;
      level         <= db_level;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/multi_button_unit.sv
// N independent button channels side by side; state_dbg packs each
// channel's 2-bit FSM state, channel i at bits [2*i+1:2*i].
module multi_button_unit
  import btn_pkg::*;
#(
  parameter int N        = 4,
  parameter bit SIM      = 1'b0,
  parameter int DB_CNT   = 1_000_000,
  parameter int LONG_CNT = 50_000_000,
  parameter int RPT_CNT  = 10_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   button_in,
  input  logic [N-1:0]   repeat_en,
  output logic [N-1:0]   press_pulse,
  output logic [N-1:0]   release_pulse,
  output logic [N-1:0]   long_pulse,
  output logic [N-1:0]   repeat_pulse,
  output logic [N-1:0]   toggle,
  output logic [N-1:0]   level,
  output logic [2*N-1:0] state_dbg
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .SIM      (SIM),
      .DB_CNT   (DB_CNT),
      .LONG_CNT (LONG_CNT),
      .RPT_CNT  (RPT_CNT)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .button        (button_in[i]),
      .repeat_en     (repeat_en[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .toggle        (toggle[i]),
      .level         (level[i]),
      .state_dbg     (state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_multi_button_unit.sv
// Directed + random bench for multi_button_unit against an event/timestamp
// model of the button rules.
module tb_multi_button_unit;

  localparam int N    = 4;
  localparam int LONG = 20;
  localparam int RPT  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   button_in;
  logic [N-1:0]   repeat_en;
  logic [N-1:0]   press_pulse, release_pulse, long_pulse, repeat_pulse, toggle, level;
  logic [2*N-1:0] state_dbg;

  always #5 clk = ~clk;

  multi_button_unit #(
    .N(N), .SIM(1'b1), .DB_CNT(1000), .LONG_CNT(LONG), .RPT_CNT(RPT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .button_in     (button_in),
    .repeat_en     (repeat_en),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .toggle        (toggle),
    .level         (level),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: accepted level from the raw sample history, strobes
  // from timestamps of press / long / repeat-enable events.
  logic [N-1:0]   samp_q[$];
  logic [6*N-1:0] exp_q[$];
  logic [N-1:0]   m_dl, m_tog;
  bit             m_pressed[N], m_long_done[N], m_rpt_on[N];
  int             m_press_t[N], m_rpt_t[N];
  int             cyc = 0;

  int stepn;
  int n_press[N], n_rel[N], n_long[N], n_rpt[N];
  int press_step[N], rel_step[N], long_step[N], rpt_first[N], rpt_last[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    exp_q.delete();
    repeat (5) samp_q.push_back('0);
    m_dl  = '0;
    m_tog = '0;
    for (int i = 0; i < N; i++) begin
      m_pressed[i]   = 0;
      m_long_done[i] = 0;
      m_rpt_on[i]    = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] p, r, l, rp;
    int sz;
    bit flip;
    p = '0; r = '0; l = '0; rp = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_pressed[i] && m_dl[i]) begin
        p[i] = 1'b1;
        m_pressed[i] = 1; m_press_t[i] = cyc; m_long_done[i] = 0; m_rpt_on[i] = 0;
        m_tog[i] = ~m_tog[i];
      end else if (m_pressed[i] && !m_dl[i]) begin
        r[i] = 1'b1;
        m_pressed[i] = 0; m_long_done[i] = 0; m_rpt_on[i] = 0;
      end else if (m_pressed[i] && !m_long_done[i]) begin
        if (cyc - m_press_t[i] == LONG) begin
          l[i] = 1'b1;
          m_long_done[i] = 1;
          m_rpt_on[i] = repeat_en[i];
          m_rpt_t[i] = cyc;
        end
      end else if (m_pressed[i]) begin
        if (m_rpt_on[i] && !repeat_en[i]) m_rpt_on[i] = 0;
        else if (!m_rpt_on[i] && repeat_en[i]) begin
          m_rpt_on[i] = 1;
          m_rpt_t[i] = cyc;
        end else if (m_rpt_on[i] && ((cyc - m_rpt_t[i]) % RPT == 0)) rp[i] = 1'b1;
      end
    end
    exp_q.push_back({p, r, l, rp, m_tog, m_dl});
    // Level flips once the last four synchronised samples all disagree with it.
    sz = samp_q.size();
    for (int i = 0; i < N; i++) begin
      flip = 1;
      for (int k = sz - 5; k <= sz - 2; k++)
        if (samp_q[k][i] == m_dl[i]) flip = 0;
      if (flip) m_dl[i] = ~m_dl[i];
    end
    samp_q.push_back(button_in);
    cyc++;
  endtask

  task automatic compare();
    logic [6*N-1:0] e;
    int c;
    e = exp_q.pop_front();
    check("press_pulse",   press_pulse,   e[6*N-1:5*N]);
    check("release_pulse", release_pulse, e[5*N-1:4*N]);
    check("long_pulse",    long_pulse,    e[4*N-1:3*N]);
    check("repeat_pulse",  repeat_pulse,  e[3*N-1:2*N]);
    check("toggle",        toggle,        e[2*N-1:N]);
    check("level",         level,         e[N-1:0]);
    for (int i = 0; i < N; i++) begin
      c = int'(press_pulse[i]) + int'(release_pulse[i]) + int'(long_pulse[i]) + int'(repeat_pulse[i]);
      check("strobe_onehot", (c <= 1), 1);
      if (press_pulse[i])   begin n_press[i]++; press_step[i] = stepn; end
      if (release_pulse[i]) begin n_rel[i]++;   rel_step[i]   = stepn; end
      if (long_pulse[i])    begin n_long[i]++;  long_step[i]  = stepn; end
      if (repeat_pulse[i]) begin
        if (n_rpt[i] == 0) rpt_first[i] = stepn;
        n_rpt[i]++;
        rpt_last[i] = stepn;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    stepn++;
    compare();
  endtask

  task automatic clear_counts();
    stepn = 0;
    for (int i = 0; i < N; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rpt[i] = 0;
      press_step[i] = -1; rel_step[i] = -1; long_step[i] = -1;
      rpt_first[i] = -1; rpt_last[i] = -1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"},   press_pulse,   0);
    check({tag, "_release"}, release_pulse, 0);
    check({tag, "_long"},    long_pulse,    0);
    check({tag, "_repeat"},  repeat_pulse,  0);
    check({tag, "_toggle"},  toggle,        0);
    check({tag, "_level"},   level,         0);
    check({tag, "_state"},   state_dbg,     0);
  endtask

  // Reset asserted mid-cycle, checked before the next edge, released on a negedge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
  endtask

  int run[N];

  initial begin
    reset     = 1'b1;
    button_in = '0;
    repeat_en = '0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Clean press and release on channel 0.
    clear_counts();
    button_in[0] = 1'b1;
    repeat (10) step();
    button_in[0] = 1'b0;
    repeat (20) step();
    check("clean_press_step", press_step[0], 7);
    check("clean_rel_step",   rel_step[0],   17);
    check("clean_press_cnt",  n_press[0],    1);
    check("clean_long_cnt",   n_long[0],     0);

    // Bounce rejection on channel 1.
    clear_counts();
    for (int len = 1; len <= 3; len++) begin
      button_in[1] = 1'b1;
      repeat (len) step();
      button_in[1] = 1'b0;
      repeat (2) step();
    end
    begin
      int mark;
      mark = stepn;
      button_in[1] = 1'b1;
      repeat (15) step();
      check("bounce_press_cnt",  n_press[1],    1);
      check("bounce_press_step", press_step[1], mark + 7);
    end
    button_in[1] = 1'b0;
    repeat (10) step();

    // Long press with auto-repeat on channel 2, then repeat disabled mid-period.
    clear_counts();
    repeat_en[2] = 1'b1;
    button_in[2] = 1'b1;
    repeat (7 + LONG + 3 * RPT + 4) step();
    repeat_en[2] = 1'b0;
    repeat (20) step();
    check("long_cnt",        n_long[2],    1);
    check("long_step",       long_step[2], press_step[2] + LONG);
    check("rpt_cnt",         n_rpt[2],     3);
    check("rpt_first_step",  rpt_first[2], long_step[2] + RPT);
    check("rpt_last_step",   rpt_last[2],  long_step[2] + 3 * RPT);
    button_in[2] = 1'b0;
    repeat (10) step();
    check("long_rel_cnt", n_rel[2], 1);

    // All channels together, then reset while held.
    do_reset("pre_sim_reset");
    button_in = '1;
    repeat (10) step();
    check("sim_toggle", toggle, 4'hF);
    for (int i = 0; i < N; i++) check("sim_press_step", press_step[i], 7);
    do_reset("hold_reset");
    repeat (10) step();
    for (int i = 0; i < N; i++) check("post_reset_press_step", press_step[i], 7);
    button_in = '0;
    repeat (12) step();

    // Release landing on the long-press maturity cycle of channel 3.
    clear_counts();
    button_in[3] = 1'b1;
    repeat (LONG) step();
    button_in[3] = 1'b0;
    repeat (15) step();
    check("collide_press_step", press_step[3], 7);
    check("collide_rel_step",   rel_step[3],   7 + LONG);
    check("collide_long_cnt",   n_long[3],     0);

    // Random runs and glitches on all channels with random repeat enables.
    for (int i = 0; i < N; i++) run[i] = 0;
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (run[i] == 0) begin
          button_in[i] = 1'($urandom_range(0, 1));
          run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 60));
        end
        run[i]--;
        if ($urandom_range(0, 15) == 0) repeat_en[i] = ~repeat_en[i];
      end
      step();
    end
    button_in = '0;
    repeat (15) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
